// File: rtl/clock_pkg.sv
// Shared definitions for the clock command path: mode codes, FSM states,
// field table, factory date and calendar helpers also used by the clock core.
package clock_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIELD  = 3'd1,
    CHECK  = 3'd2,
    COMMIT = 3'd3,
    ERR    = 3'd4
  } state_e;

  localparam logic [2:0] MODE_ALARM_OFF = 3'd0;
  localparam logic [2:0] MODE_FMT12     = 3'd1;
  localparam logic [2:0] MODE_FMT24     = 3'd2;
  localparam logic [2:0] MODE_SET_TIME  = 3'd3;
  localparam logic [2:0] MODE_SET_ALARM = 3'd4;
  localparam logic [2:0] MODE_TIMER     = 3'd5;
  localparam logic [2:0] MODE_FACTORY   = 3'd6;

  localparam int NUM_FIELDS = 6;
  typedef logic [NUM_FIELDS-1:0][11:0] staging_t;

  localparam logic [4:0]  RESET_DAY     = 5'd1;
  localparam logic [3:0]  RESET_MONTH   = 4'd1;
  localparam logic [11:0] RESET_YEAR    = 12'd2020;
  localparam logic [4:0]  FACTORY_DAY   = 5'd1;
  localparam logic [3:0]  FACTORY_MONTH = 4'd1;
  localparam logic [11:0] FACTORY_YEAR  = 12'd2024;

  function automatic logic [2:0] field_count(input logic [2:0] mode);
    case (mode)
      MODE_SET_TIME:  return 3'd6;
      MODE_SET_ALARM: return 3'd3;
      MODE_TIMER:     return 3'd2;
      default:        return 3'd0;
    endcase
  endfunction

  function automatic logic is_leap(input logic [11:0] year);
    return (((year % 12'd4) == 12'd0) && ((year % 12'd100) != 12'd0)) ||
           ((year % 12'd400) == 12'd0);
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic [11:0] year);
    case (month)
      4'd2:                       return is_leap(year) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:    return 5'd30;
      default:                    return 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/cmd_range_check.sv
// Combinational validator: checks the staged fields of a command against
// the legal ranges of its mode, on the full 12-bit beat values.
module cmd_range_check
  import clock_pkg::*;
#(
  parameter int YEAR_MIN = 2020,
  parameter int YEAR_MAX = 2025
) (
  input  logic [11:0] mode,
  input  staging_t    fields,
  output logic        ok
);

  localparam logic [11:0] YMIN = 12'(YEAR_MIN);
  localparam logic [11:0] YMAX = 12'(YEAR_MAX);

  logic       hms_ok_s;
  logic       date_ok_s;
  logic       timer_ok_s;
  logic [4:0] dim_s;

  // Field legality per mode
  always_comb begin
    hms_ok_s   = (fields[0] <= 12'd23) && (fields[1] <= 12'd59) && (fields[2] <= 12'd59);
    dim_s      = days_in_month(fields[4][3:0], fields[5]);
    date_ok_s  = (fields[4] >= 12'd1) && (fields[4] <= 12'd12) &&
                 (fields[5] >= YMIN) && (fields[5] <= YMAX) &&
                 (fields[3] >= 12'd1) && (fields[3] <= {7'd0, dim_s});
    timer_ok_s = (fields[0] <= 12'd59) && (fields[1] <= 12'd59) &&
                 ((fields[0] != 12'd0) || (fields[1] != 12'd0));
    case (mode)
      {9'd0, MODE_ALARM_OFF},
      {9'd0, MODE_FMT12},
      {9'd0, MODE_FMT24},
      {9'd0, MODE_FACTORY}:   ok = 1'b1;
      {9'd0, MODE_SET_TIME}:  ok = hms_ok_s && date_ok_s;
      {9'd0, MODE_SET_ALARM}: ok = hms_ok_s;
      {9'd0, MODE_TIMER}:     ok = timer_ok_s;
      default:                ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/clock_cmd_controller.sv
// Beat-serial command sequencer for the clock core: collects mode + fields,
// range-checks them and drives the core's set/alarm/timer/format inputs.
module clock_cmd_controller
  import clock_pkg::*;
#(
  parameter int TIMEOUT_CYC = 30,
  parameter int YEAR_MIN    = 2020,
  parameter int YEAR_MAX    = 2025
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [11:0] cmd_data,
  output logic        cmd_ready,
  output logic        load_time,
  output logic [4:0]  set_hour,
  output logic [5:0]  set_min,
  output logic [5:0]  set_sec,
  output logic [4:0]  set_day,
  output logic [3:0]  set_month,
  output logic [11:0] set_year,
  output logic [4:0]  alarm_hour,
  output logic [5:0]  alarm_min,
  output logic [5:0]  alarm_sec,
  output logic        alarm_enable,
  output logic [5:0]  timer_min,
  output logic [5:0]  timer_sec,
  output logic        timer_start,
  output logic        fmt_24h,
  output logic        cmd_done,
  output logic        cmd_err
);

  localparam int            TW           = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] CNT_ONE      = TW'(1);

  state_e        state_r, next_state_s;
  logic          cmd_ready_r;
  logic [2:0]    mode_r, field_cnt_r, nfields_s;
  logic [TW-1:0] idle_cnt_r;
  staging_t      staging_r, stage_view_s;
  logic [11:0]   check_mode_s;
  logic          beat_s, last_beat_s, mode_known_s, ok_s, ok_r;

  logic [4:0]  set_hour_r, set_day_r, alarm_hour_r;
  logic [5:0]  set_min_r, set_sec_r, alarm_min_r, alarm_sec_r, timer_min_r, timer_sec_r;
  logic [3:0]  set_month_r;
  logic [11:0] set_year_r;
  logic        alarm_enable_r, fmt_24h_r, load_time_r, timer_start_r, cmd_done_r, cmd_err_r;

  // Beat decode; the validator sees the staging with the incoming beat merged in
  always_comb begin
    beat_s       = cmd_valid && cmd_ready_r;
    mode_known_s = (cmd_data <= 12'd6);
    check_mode_s = (state_r == IDLE) ? cmd_data : {9'd0, mode_r};
    nfields_s    = field_count(check_mode_s[2:0]);
    stage_view_s = staging_r;
    if ((state_r == FIELD) && beat_s) begin
      stage_view_s[field_cnt_r] = cmd_data;
    end else begin
      stage_view_s = staging_r;
    end
    last_beat_s = (state_r == FIELD) && beat_s && (field_cnt_r == (nfields_s - 3'd1));
  end

  cmd_range_check #(
    .YEAR_MIN(YEAR_MIN),
    .YEAR_MAX(YEAR_MAX)
  ) u_range_check (
    .mode  (check_mode_s),
    .fields(stage_view_s),
    .ok    (ok_s)
  );

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!beat_s) begin
          next_state_s = IDLE;
        end else if (!mode_known_s) begin
          next_state_s = ERR;
        end else if (nfields_s == 3'd0) begin
          next_state_s = CHECK;
        end else begin
          next_state_s = FIELD;
        end
      end
      FIELD: begin
        if (last_beat_s) begin
          next_state_s = CHECK;
        end else if (beat_s) begin
          next_state_s = FIELD;
        end else if (idle_cnt_r == TIMEOUT_LAST) begin
          next_state_s = ERR;
        end else begin
          next_state_s = FIELD;
        end
      end
      CHECK:   next_state_s = ok_r ? COMMIT : ERR;
      COMMIT:  next_state_s = IDLE;
      ERR:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM, staging and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b1;
      mode_r      <= 3'd0;
      field_cnt_r <= 3'd0;
      idle_cnt_r  <= '0;
      staging_r   <= '0;
      ok_r        <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      cmd_ready_r <= (next_state_s == IDLE) || (next_state_s == FIELD);
      if (next_state_s == CHECK) ok_r <= ok_s;
      if ((state_r == IDLE) && beat_s) begin
        mode_r      <= cmd_data[2:0];
        staging_r   <= '0;
        field_cnt_r <= 3'd0;
      end else if ((state_r == FIELD) && beat_s) begin
        staging_r   <= stage_view_s;
        field_cnt_r <= field_cnt_r + 3'd1;
      end
      if (beat_s || (state_r != FIELD)) idle_cnt_r <= '0;
      else                              idle_cnt_r <= idle_cnt_r + CNT_ONE;
    end
  end

  // Registered outputs; set_* move on entry to CHECK so they lead load_time by a cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_time_r    <= 1'b0;
      timer_start_r  <= 1'b0;
      cmd_done_r     <= 1'b0;
      cmd_err_r      <= 1'b0;
      set_hour_r     <= 5'd0;
      set_min_r      <= 6'd0;
      set_sec_r      <= 6'd0;
      set_day_r      <= RESET_DAY;
      set_month_r    <= RESET_MONTH;
      set_year_r     <= RESET_YEAR;
      alarm_hour_r   <= 5'd0;
      alarm_min_r    <= 6'd0;
      alarm_sec_r    <= 6'd0;
      alarm_enable_r <= 1'b0;
      timer_min_r    <= 6'd0;
      timer_sec_r    <= 6'd0;
      fmt_24h_r      <= 1'b0;
    end else begin
      load_time_r   <= (state_r == CHECK) && ok_r &&
                       ((mode_r == MODE_SET_TIME) || (mode_r == MODE_FACTORY));
      timer_start_r <= (state_r == CHECK) && ok_r && (mode_r == MODE_TIMER);
      cmd_done_r    <= (state_r == CHECK) && ok_r;
      cmd_err_r     <= (next_state_s == ERR);
      if ((next_state_s == CHECK) && ok_s) begin
        if (check_mode_s == {9'd0, MODE_SET_TIME}) begin
          set_hour_r  <= stage_view_s[0][4:0];
          set_min_r   <= stage_view_s[1][5:0];
          set_sec_r   <= stage_view_s[2][5:0];
          set_day_r   <= stage_view_s[3][4:0];
          set_month_r <= stage_view_s[4][3:0];
          set_year_r  <= stage_view_s[5];
        end else if (check_mode_s == {9'd0, MODE_FACTORY}) begin
          set_hour_r  <= 5'd0;
          set_min_r   <= 6'd0;
          set_sec_r   <= 6'd0;
          set_day_r   <= FACTORY_DAY;
          set_month_r <= FACTORY_MONTH;
          set_year_r  <= FACTORY_YEAR;
        end
      end
      if ((state_r == CHECK) && ok_r) begin
        case (mode_r)
          MODE_SET_ALARM: begin
            alarm_hour_r   <= staging_r[0][4:0];
            alarm_min_r    <= staging_r[1][5:0];
            alarm_sec_r    <= staging_r[2][5:0];
            alarm_enable_r <= 1'b1;
          end
          MODE_ALARM_OFF: alarm_enable_r <= 1'b0;
          MODE_FMT12:     fmt_24h_r      <= 1'b0;
          MODE_FMT24:     fmt_24h_r      <= 1'b1;
          MODE_TIMER: begin
            timer_min_r <= staging_r[0][5:0];
            timer_sec_r <= staging_r[1][5:0];
          end
          default:        fmt_24h_r      <= fmt_24h_r;
        endcase
      end
    end
  end

  assign cmd_ready    = cmd_ready_r;
  assign load_time    = load_time_r;
  assign set_hour     = set_hour_r;
  assign set_min      = set_min_r;
  assign set_sec      = set_sec_r;
  assign set_day      = set_day_r;
  assign set_month    = set_month_r;
  assign set_year     = set_year_r;
  assign alarm_hour   = alarm_hour_r;
  assign alarm_min    = alarm_min_r;
  assign alarm_sec    = alarm_sec_r;
  assign alarm_enable = alarm_enable_r;
  assign timer_min    = timer_min_r;
  assign timer_sec    = timer_sec_r;
  assign timer_start  = timer_start_r;
  assign fmt_24h      = fmt_24h_r;
  assign cmd_done     = cmd_done_r;
  assign cmd_err      = cmd_err_r;

endmodule

// File: tb/tb_clock_cmd_controller.sv
// Scoreboard bench for clock_cmd_controller: each command pushes its expected
// outcome; a negedge monitor pops and compares when done/err pulses.
module tb_clock_cmd_controller;

  localparam int TIMEOUT_CYC = 30;
  localparam logic [37:0] SET_RESET   = {5'd0, 6'd0, 6'd0, 5'd1, 4'd1, 12'd2020};
  localparam logic [37:0] SET_FACTORY = {5'd0, 6'd0, 6'd0, 5'd1, 4'd1, 12'd2024};

  logic        clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
  logic [11:0] cmd_data = 12'd0;
  logic        cmd_ready, load_time, alarm_enable, timer_start, fmt_24h, cmd_done, cmd_err;
  logic [4:0]  set_hour, set_day, alarm_hour;
  logic [5:0]  set_min, set_sec, alarm_min, alarm_sec, timer_min, timer_sec;
  logic [3:0]  set_month;
  logic [11:0] set_year;

  clock_cmd_controller #(.TIMEOUT_CYC(TIMEOUT_CYC), .YEAR_MIN(2020), .YEAR_MAX(2025)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .load_time(load_time), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .set_day(set_day), .set_month(set_month), .set_year(set_year),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_sec(alarm_sec),
    .alarm_enable(alarm_enable), .timer_min(timer_min), .timer_sec(timer_sec),
    .timer_start(timer_start), .fmt_24h(fmt_24h), .cmd_done(cmd_done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          err;
    bit          load;
    bit          tstart;
    int          at;
    logic [37:0] tset;
    logic [17:0] alarm;
    logic [11:0] timer;
    logic        fmt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0, failures = 0, last_acc = 0;
  logic [37:0] m_set, prev_set, cur_set;
  logic [17:0] m_alarm, cur_alarm;
  logic [11:0] m_timer, cur_timer;
  logic        m_fmt;

  assign cur_set   = {set_hour, set_min, set_sec, set_day, set_month, set_year};
  assign cur_alarm = {alarm_hour, alarm_min, alarm_sec, alarm_enable};
  assign cur_timer = {timer_min, timer_sec};

  // Scoreboard monitor: every done/err pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_done || cmd_err) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_pulse: done=%0d err=%0d at cycle %0d, required none", cmd_done, cmd_err, cyc);
        end else begin
          mon_e = sb.pop_front();
          checks++;
          if ({cmd_done, cmd_err, load_time, timer_start} !== {!mon_e.err, mon_e.err, mon_e.load, mon_e.tstart}) begin
            failures++;
            $display("FAIL pulse_kind: done/err/load/tstart=%b required %b", {cmd_done, cmd_err, load_time, timer_start},
                     {!mon_e.err, mon_e.err, mon_e.load, mon_e.tstart});
          end
          checks++;
          if (cyc != mon_e.at) begin
            failures++; $display("FAIL latency: pulse at cycle %0d required %0d", cyc, mon_e.at);
          end
          checks++;
          if (cur_set !== mon_e.tset) begin
            failures++; $display("FAIL set_fields: got %h required %h", cur_set, mon_e.tset);
          end
          checks++;
          if (cur_alarm !== mon_e.alarm) begin
            failures++; $display("FAIL alarm_fields: got %h required %h", cur_alarm, mon_e.alarm);
          end
          checks++;
          if (cur_timer !== mon_e.timer) begin
            failures++; $display("FAIL timer_fields: got %h required %h", cur_timer, mon_e.timer);
          end
          checks++;
          if (fmt_24h !== mon_e.fmt) begin
            failures++; $display("FAIL fmt_24h: got %b required %b", fmt_24h, mon_e.fmt);
          end
          if (load_time) begin
            checks++;
            if (prev_set !== cur_set) begin
              failures++; $display("FAIL set_stable: before load %h, during load %h", prev_set, cur_set);
            end
          end
        end
      end else if (load_time || timer_start) begin
        checks++; failures++;
        $display("FAIL stray_pulse: load=%0d tstart=%0d without cmd_done at cycle %0d", load_time, timer_start, cyc);
      end
    end
    prev_set = cur_set;
  end

  task automatic model_reset();
    m_set = SET_RESET; m_alarm = 18'd0; m_timer = 12'd0; m_fmt = 1'b0;
  endtask

  task automatic drive_beat(input int v);
    int k = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && k < 60) begin @(negedge clk); k++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL ready_wait: cmd_ready=%b after %0d cycles, required 1", cmd_ready, k);
    end
    cmd_valid = 1'b1; cmd_data = 12'(v);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_data = 12'd0;
    last_acc = cyc;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin @(negedge clk); #1; k++; end
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL drain: %0d results pending after %0d cycles, required 0", sb.size(), k);
      sb.delete();
    end
  endtask

  task automatic send_cmd(input bit ok, input bit wait_done, input int n, input int b0,
                          input int b1 = 0, input int b2 = 0, input int b3 = 0,
                          input int b4 = 0, input int b5 = 0, input int b6 = 0);
    exp_t e;
    int   bs[7];
    bs = '{b0, b1, b2, b3, b4, b5, b6};
    for (int i = 0; i < n; i++) drive_beat(bs[i]);
    if (ok) begin
      case (b0)
        3:       m_set = {5'(b1), 6'(b2), 6'(b3), 5'(b4), 4'(b5), 12'(b6)};
        6:       m_set = SET_FACTORY;
        4:       m_alarm = {5'(b1), 6'(b2), 6'(b3), 1'b1};
        0:       m_alarm[0] = 1'b0;
        1:       m_fmt = 1'b0;
        2:       m_fmt = 1'b1;
        5:       m_timer = {6'(b1), 6'(b2)};
        default: m_fmt = m_fmt;
      endcase
    end
    e.err = !ok; e.load = ok && (b0 == 3 || b0 == 6); e.tstart = ok && (b0 == 5);
    e.at = (b0 > 6) ? last_acc : last_acc + 1;
    e.tset = m_set; e.alarm = m_alarm; e.timer = m_timer; e.fmt = m_fmt;
    sb.push_back(e);
    if (wait_done) drain(20);
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cur_set !== SET_RESET) begin failures++; $display("FAIL reset_set: got %h required %h", cur_set, SET_RESET); end
    checks++; if (cur_alarm !== 18'd0) begin failures++; $display("FAIL reset_alarm: got %h required 0", cur_alarm); end
    checks++; if (cur_timer !== 12'd0) begin failures++; $display("FAIL reset_timer: got %h required 0", cur_timer); end
    checks++; if ({load_time, timer_start, cmd_done, cmd_err, fmt_24h} !== 5'd0) begin
      failures++; $display("FAIL reset_flags: got %b required 00000", {load_time, timer_start, cmd_done, cmd_err, fmt_24h});
    end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
    reset = 1'b0;
  endtask

  task automatic test_set_time();
    send_cmd(1, 1, 7, 3, 13, 45, 10, 29, 2, 2024);
    send_cmd(0, 1, 7, 3, 10, 0, 0, 29, 2, 2023);
    checks++; if (cur_set !== {5'd13, 6'd45, 6'd10, 5'd29, 4'd2, 12'd2024}) begin
      failures++; $display("FAIL set_after_err: got %h required 13:45:10 29/2/2024", cur_set);
    end
    send_cmd(1, 1, 7, 3, 23, 59, 59, 31, 12, 2025);
    send_cmd(0, 1, 7, 3, 0, 0, 0, 31, 4, 2024);
    send_cmd(0, 1, 7, 3, 24, 0, 0, 1, 1, 2024);
    send_cmd(0, 1, 7, 3, 0, 0, 0, 1, 1, 2026);
    send_cmd(0, 1, 7, 3, 0, 0, 0, 1, 13, 2021);
  endtask

  task automatic test_alarm();
    send_cmd(1, 1, 4, 4, 7, 30, 0);
    checks++; if (alarm_enable !== 1'b1) begin failures++; $display("FAIL alarm_on: got %b required 1", alarm_enable); end
    send_cmd(1, 1, 1, 0);
    checks++; if ({alarm_enable, alarm_hour} !== {1'b0, 5'd7}) begin
      failures++; $display("FAIL alarm_off: en/hour=%b/%0d required 0/7", alarm_enable, alarm_hour);
    end
    send_cmd(0, 1, 4, 4, 12, 60, 0);
  endtask

  task automatic test_timer();
    send_cmd(1, 1, 3, 5, 2, 15);
    send_cmd(0, 1, 3, 5, 0, 0);
    send_cmd(0, 1, 3, 5, 64, 1);
    send_cmd(1, 1, 3, 5, 0, 1);
    send_cmd(1, 1, 3, 5, 59, 59);
  endtask

  task automatic test_format();
    send_cmd(1, 1, 1, 2);
    checks++; if (fmt_24h !== 1'b1) begin failures++; $display("FAIL fmt24: got %b required 1", fmt_24h); end
    send_cmd(1, 1, 1, 1);
  endtask

  task automatic test_back_to_back();
    int p;
    send_cmd(1, 0, 1, 2);
    p = last_acc;
    send_cmd(1, 0, 1, 1);
    checks++;
    if (last_acc - p != 3) begin failures++; $display("FAIL b2b_gap: %0d cycles required 3", last_acc - p); end
    drain(20);
  endtask

  task automatic test_timeout();
    exp_t e;
    drive_beat(3);
    drive_beat(12);
    e.err = 1'b1; e.load = 1'b0; e.tstart = 1'b0; e.at = last_acc + TIMEOUT_CYC;
    e.tset = m_set; e.alarm = m_alarm; e.timer = m_timer; e.fmt = m_fmt;
    sb.push_back(e);
    drain(TIMEOUT_CYC + 10);
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL timeout_ready: got %b required 1", cmd_ready); end
    send_cmd(1, 1, 1, 2);
    checks++; if (fmt_24h !== 1'b1) begin failures++; $display("FAIL fmt_after_timeout: got %b required 1", fmt_24h); end
  endtask

  task automatic test_bad_mode_and_reset();
    send_cmd(0, 1, 1, 9);
    send_cmd(0, 1, 1, 7);
    send_cmd(0, 1, 1, 4095);
    drive_beat(3); drive_beat(1); drive_beat(2);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if ({cur_set, cur_alarm, cur_timer, fmt_24h} !== {SET_RESET, 18'd0, 12'd0, 1'b0}) begin
      failures++; $display("FAIL midreset_outputs: set=%h alarm=%h timer=%h fmt=%b required reset values",
                           cur_set, cur_alarm, cur_timer, fmt_24h);
    end
    checks++; if ({cmd_ready, load_time, cmd_done, cmd_err} !== 4'b1000) begin
      failures++; $display("FAIL midreset_flags: got %b required 1000", {cmd_ready, load_time, cmd_done, cmd_err});
    end
    reset = 1'b0;
    send_cmd(1, 1, 1, 6);
    checks++; if (cur_set !== SET_FACTORY) begin failures++; $display("FAIL factory: got %h required %h", cur_set, SET_FACTORY); end
  endtask

  initial begin
    test_reset();
    test_set_time();
    test_alarm();
    test_timer();
    test_format();
    test_back_to_back();
    test_timeout();
    test_bad_mode_and_reset();
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL final_queue: %0d pending required 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
